// File: rtl/matmul_pkg.sv
// Shared defaults, FSM state type and accumulator sizing for matmul_seq.
package matmul_pkg;
    localparam int N_DEF  = 4;
    localparam int DW_DEF = 8;
    localparam int OW_DEF = 16;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    // Worst case sum is N * (2^DW-1)^2, which always fits in 2*DW+clog2(N) bits.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction
endpackage

// File: rtl/mac_unit.sv
// Two-stage multiply-accumulate: registered product, then accumulate/emit on the tagged last term.
// MATMUL_SAT_EN selects saturate-to-max on the emitted element; otherwise it is truncated to OW bits.
module mac_unit #(
    parameter int DW = 8,
    parameter int OW = 16,
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    input  logic          last,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          res_valid,
    output logic [OW-1:0] res_val,
    output logic          res_sat
);
    logic [2*DW-1:0] prod_q;
    logic            prod_vld;
    logic            prod_last;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   sum;

    always_ff @(posedge clk) begin
        if (clr) begin
            prod_q    <= '0;
            prod_vld  <= 1'b0;
            prod_last <= 1'b0;
            acc       <= '0;
        end else begin
            prod_q    <= a * b;
            prod_vld  <= en;
            prod_last <= en & last;
            if (prod_vld)
                acc <= prod_last ? '0 : sum;
        end
    end

    assign sum       = acc + AW'(prod_q);
    assign res_valid = prod_vld & prod_last;

`ifdef MATMUL_SAT_EN
    localparam int CW = (AW > OW) ? AW : OW;
    logic [CW-1:0] sum_x;
    assign sum_x   = CW'(sum);
    assign res_sat = sum_x > CW'({OW{1'b1}});
    assign res_val = res_sat ? {OW{1'b1}} : sum_x[OW-1:0];
`else
    assign res_sat = 1'b0;
    assign res_val = OW'(sum);
`endif
endmodule

// File: rtl/matmul_seq.sv
// Sequential NxN matrix multiplier: one MAC per cycle in i/j/k order over captured operands.
// Optional saturation of result elements is enabled with MATMUL_SAT_EN.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N*N*DW-1:0] a_flat,
    input  logic [N*N*DW-1:0] b_flat,
    output logic              busy,
    output logic              done,
    output logic [N*N*OW-1:0] result_flat,
    output logic              sat_flag
);
    localparam int AW = acc_width(N, DW);
    localparam int IW = $clog2(N);
    localparam int EW = $clog2(N * N);
    localparam logic [IW-1:0] IMAX = IW'(N - 1);
    localparam logic [EW-1:0] EMAX = EW'(N * N - 1);

    state_t            state, state_nx;
    logic [N*N*DW-1:0] a_q, b_q;
    logic [IW-1:0]     i_idx, j_idx, k_idx;
    logic [EW-1:0]     wr_idx;
    logic              issuing;
    logic              accept;
    logic [DW-1:0]     a_op, b_op;
    logic              res_valid, res_sat;
    logic [OW-1:0]     res_val;

    assign accept = (state == IDLE) && start && !reset;
    assign a_op   = a_q[(int'(i_idx) * N + int'(k_idx)) * DW +: DW];
    assign b_op   = b_q[(int'(k_idx) * N + int'(j_idx)) * DW +: DW];
    assign busy   = (state == COMPUTE);
    assign done   = (state == DONE);

    mac_unit #(.DW(DW), .OW(OW), .AW(AW)) u_mac (
        .clk       (clk),
        .clr       (reset | accept),
        .en        ((state == COMPUTE) && issuing),
        .last      (k_idx == IMAX),
        .a         (a_op),
        .b         (b_op),
        .res_valid (res_valid),
        .res_val   (res_val),
        .res_sat   (res_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = COMPUTE;
            COMPUTE: if (res_valid && wr_idx == EMAX) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            i_idx       <= '0;
            j_idx       <= '0;
            k_idx       <= '0;
            wr_idx      <= '0;
            issuing     <= 1'b0;
            result_flat <= '0;
            sat_flag    <= 1'b0;
        end else if (accept) begin
            a_q      <= a_flat;
            b_q      <= b_flat;
            i_idx    <= '0;
            j_idx    <= '0;
            k_idx    <= '0;
            wr_idx   <= '0;
            issuing  <= 1'b1;
            sat_flag <= 1'b0;
        end else begin
            if (state == COMPUTE && issuing) begin
                if (k_idx == IMAX) begin
                    k_idx <= '0;
                    if (j_idx == IMAX) begin
                        j_idx <= '0;
                        if (i_idx == IMAX) issuing <= 1'b0;
                        else               i_idx   <= i_idx + IW'(1);
                    end else begin
                        j_idx <= j_idx + IW'(1);
                    end
                end else begin
                    k_idx <= k_idx + IW'(1);
                end
            end
            // Elements retire in row-major order, one behind the issue pipeline.
            if (res_valid) begin
                result_flat[int'(wr_idx) * OW +: OW] <= res_val;
                wr_idx <= wr_idx + EW'(1);
                if (res_sat) sat_flag <= 1'b1;
            end
        end
    end
endmodule
